packet_builder: RTL and testbench

PACKET_BUILDER -- requirements
Module: packet_builder

---
 rtl/packet_builder_pkg.sv | 37 +++
 rtl/packet_fifo.sv | 62 ++++++
 rtl/packet_builder.sv | 63 ++++++
 tb/tb_packet_builder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_builder_pkg.sv
// Shared definitions for the write-packet format.
// Used by packet_builder and by any receiver-side checker decoding the packets.
// Packet layout: [3:0] header, [11:4] address, [27:12] data, [31:28] sequence.
package packet_builder_pkg;

  localparam logic [3:0] HDR_WRITE = 4'hE;

  localparam int unsigned HDR_LSB  = 0;
  localparam int unsigned HDR_W    = 4;
  localparam int unsigned ADDR_LSB = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_LSB = 12;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SEQ_LSB  = 28;
  localparam int unsigned SEQ_W    = 4;
  localparam int unsigned PKT_W    = 32;

  // Field order is MSB first, so this struct maps exactly onto the layout above.
  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [HDR_W-1:0]  hdr;
  } pkt_t;

  function automatic pkt_t encode_write(input logic [SEQ_W-1:0]  seq,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
    pkt_t p;
    p.seq  = seq;
    p.data = data;
    p.addr = addr;
    p.hdr  = HDR_WRITE;
    return p;
  endfunction

endpackage

// File: rtl/packet_fifo.sv
// Synchronous FIFO holding encoded packets.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request (ignored when full)
//   pop          : read request (ignored when empty)
//   rdata        : head entry from storage, zero when empty
//   full, empty  : status derived from the registered count
//   count        : number of stored entries, 0..DEPTH
module packet_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rptr];

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/packet_builder.sv
// Encodes RAM write requests into 32-bit packets and buffers them in a FIFO.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : request handshake (in_ready from registered state only)
//   in_addr, in_data    : request address (8b) and data (16b)
//   out_valid, out_ready: packet handshake
//   packet_out          : head packet, zero when no packet is buffered
//   level               : number of buffered packets
module packet_builder
  import packet_builder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PKT_W-1:0]       packet_out,
  output logic [$clog2(DEPTH):0] level
);

  logic             accept;
  logic             full;
  logic             empty;
  logic [SEQ_W-1:0] seq;
  pkt_t             pkt;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;

  always_comb begin
    pkt = encode_write(seq, in_addr, in_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= '0;
    end else if (accept) begin
      seq <= seq + SEQ_W'(1);
    end
  end

  packet_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (out_ready),
    .wdata (pkt),
    .rdata (packet_out),
    .full  (full),
    .empty (empty),
    .count (level)
  );

endmodule

// File: tb/tb_packet_builder.sv
module tb_packet_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_addr = '0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] packet_out;
  logic [2:0]  level;

  int tests = 0;
  int fails = 0;

  logic [31:0] sb[$];
  logic [31:0] got[$];
  logic [3:0]  exp_seq = '0;

  packet_builder #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .packet_out (packet_out),
    .level      (level)
  );

  always #5 clk = ~clk;

  // Scoreboard: handshakes seen mid-cycle are the ones the next rising edge takes.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_seq = '0;
    end else begin
      if (out_valid && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow: got packet %h, expected none", packet_out);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          if (packet_out !== e) begin
            fails++;
            $display("FAIL sb_packet: got %h, expected %h", packet_out, e);
          end
        end
        got.push_back(packet_out);
      end
      if (in_valid && in_ready) begin
        sb.push_back({exp_seq, in_data, in_addr, 4'hE});
        exp_seq = exp_seq + 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    got.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL drain: out_valid=%b sb_left=%0d, expected 0/0", out_valid, sb.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    tests++;
    if (packet_out !== 32'h0) begin fails++; $display("FAIL reset_packet_out: got %h, expected 0", packet_out); end
    tests++;
    if (level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d, expected 0", level); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    do_reset();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 8'h12;
    in_data   = 16'hABCD;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b, expected 1", out_valid); end
    tests++;
    if (packet_out !== 32'h0ABCD12E) begin fails++; $display("FAIL single_packet: got %h, expected 0abcd12e", packet_out); end
    tick();
    tests++;
    if (level !== 3'd0) begin fails++; $display("FAIL single_level: got %0d, expected 0", level); end
    drain();
  endtask

  task automatic test_fill();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_addr = 8'h20 + 8'(i);
      in_data = 16'h1000 + 16'(i);
      tick();
      if (i >= 3) begin
        tests++;
        if (in_ready !== 1'b0 || level !== 3'd4) begin
          fails++;
          $display("FAIL fill_full_%0d: in_ready=%b level=%0d, expected 0/4", i, in_ready, level);
        end
      end
    end
    out_ready = 1'b1;
    tick();
    tick();
    tests++;
    if (level !== 3'd3) begin fails++; $display("FAIL fill_refill_level: got %0d, expected 3", level); end
    drain();
    tests++;
    if (got.size() != 5) begin
      fails++;
      $display("FAIL fill_count: got %0d packets, expected 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (got[i] !== {4'(i), 16'h1000 + 16'(i), 8'h20 + 8'(i), 4'hE}) begin
          fails++;
          $display("FAIL fill_order_%0d: got %h, expected seq %0d addr %h", i, got[i], i, 8'h20 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_addr = 8'h40 + 8'(i);
      in_data = 16'h2000 + 16'(i);
      tick();
    end
    tests++;
    if (level !== 3'd2) begin fails++; $display("FAIL simul_pre_level: got %0d, expected 2", level); end
    out_ready = 1'b1;
    for (int i = 2; i < 5; i++) begin
      in_addr = 8'h40 + 8'(i);
      in_data = 16'h2000 + 16'(i);
      tick();
      tests++;
      if (level !== 3'd2) begin fails++; $display("FAIL simul_level_%0d: got %0d, expected 2", i, level); end
    end
    drain();
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      tests++;
      if (got[i][31:28] !== 4'(i)) begin
        fails++;
        $display("FAIL simul_seq_%0d: got %0d, expected %0d", i, got[i][31:28], i);
      end
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_addr = 8'(i);
      in_data = 16'hC000 + 16'(i);
      tick();
    end
    drain();
    tests++;
    if (got.size() != 17) begin
      fails++;
      $display("FAIL wrap_count: got %0d packets, expected 17", got.size());
    end else begin
      tests++;
      if (got[15][31:28] !== 4'hF) begin fails++; $display("FAIL wrap_seq15: got %h, expected f", got[15][31:28]); end
      tests++;
      if (got[16][31:28] !== 4'h0) begin fails++; $display("FAIL wrap_seq16: got %h, expected 0", got[16][31:28]); end
    end
  endtask

  task automatic test_stable();
    logic [31:0] held;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_addr = 8'h60 + 8'(i);
      in_data = 16'h3000 + 16'(i);
      tick();
    end
    held = packet_out;
    tests++;
    if (held !== 32'h0300060E) begin fails++; $display("FAIL stable_head: got %h, expected 0300060e", held); end
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_addr  = 8'($urandom);
      in_data  = 16'($urandom);
      tick();
      tests++;
      if (packet_out !== held || level !== 3'd4) begin
        fails++;
        $display("FAIL stable_%0d: packet=%h level=%0d, expected %h/4", i, packet_out, level, held);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_addr = 8'h80 + 8'(i);
      in_data = 16'h4000 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (level !== 3'd3) begin fails++; $display("FAIL mid_pre_level: got %0d, expected 3", level); end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      fails++;
      $display("FAIL mid_reset: out_valid=%b level=%0d, expected 0/0", out_valid, level);
    end
    sb.delete();
    got.delete();
    exp_seq = '0;
    #1 rst_n = 1'b1;
    tick();
    in_valid  = 1'b1;
    in_addr   = 8'h99;
    in_data   = 16'h5555;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (packet_out !== 32'h0555599E) begin
      fails++;
      $display("FAIL mid_first_after: got %h, expected 0555599e", packet_out);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simultaneous();
    test_seq_wrap();
    test_stable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
